// File: rtl/id_ex_if.sv
// ID->EX pipeline bundle: decode-side operands/controls in, registered EX-side values out.
// The master drives decode, writeback, flush and stall; the slave is the ID/EX stage.
interface id_ex_if;
    logic        id_valid;
    logic [31:0] pc_id;
    logic [31:0] reg_1_id;
    logic [31:0] reg_2_id;
    logic [31:0] imm_data_id;
    logic [4:0]  rs1_addr_id;
    logic [4:0]  rs2_addr_id;
    logic [4:0]  rd_addr_id;
    logic [1:0]  alu_mode_select_id;
    logic [4:0]  alu_op_id;
    logic        reg_write_id;
    logic        mem_read_id;
    logic        mem_write_id;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        flush_in;
    logic        mem_stall_in;

    logic        ex_valid;
    logic [31:0] pc_ex;
    logic [31:0] reg_1_out;
    logic [31:0] reg_2_out;
    logic [31:0] imm_data_out;
    logic [1:0]  alu_mode_select_ex;
    logic [4:0]  alu_op_ex;
    logic [4:0]  rd_addr_ex;
    logic        reg_write_ex;
    logic        mem_read_ex;
    logic        mem_write_ex;
    logic        id_stall_out;
    logic [15:0] bubble_cnt_out;

    modport master (
        output id_valid, pc_id, reg_1_id, reg_2_id, imm_data_id,
               rs1_addr_id, rs2_addr_id, rd_addr_id,
               alu_mode_select_id, alu_op_id,
               reg_write_id, mem_read_id, mem_write_id,
               wb_reg_write, wb_rd_addr, wb_data, flush_in, mem_stall_in,
        input  ex_valid, pc_ex, reg_1_out, reg_2_out, imm_data_out,
               alu_mode_select_ex, alu_op_ex, rd_addr_ex,
               reg_write_ex, mem_read_ex, mem_write_ex,
               id_stall_out, bubble_cnt_out
    );

    modport slave (
        input  id_valid, pc_id, reg_1_id, reg_2_id, imm_data_id,
               rs1_addr_id, rs2_addr_id, rd_addr_id,
               alu_mode_select_id, alu_op_id,
               reg_write_id, mem_read_id, mem_write_id,
               wb_reg_write, wb_rd_addr, wb_data, flush_in, mem_stall_in,
        output ex_valid, pc_ex, reg_1_out, reg_2_out, imm_data_out,
               alu_mode_select_ex, alu_op_ex, rd_addr_ex,
               reg_write_ex, mem_read_ex, mem_write_ex,
               id_stall_out, bubble_cnt_out
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and writeback bypass.
// Latency: one cycle ID->EX; id_stall_out is combinational.
// Backpressure: mem_stall_in freezes every EX register; a flush seen under stall is deferred.
module id_ex_stage #(
    parameter logic [4:0] NOP_ALU_OP = 5'd0,
    parameter logic [1:0] NOP_MODE   = 2'd0
) (
    input logic   clk,
    input logic   rst,
    id_ex_if.slave bus
);
    logic        r_ex_valid;
    logic [31:0] r_pc_ex;
    logic [31:0] r_reg_1;
    logic [31:0] r_reg_2;
    logic [31:0] r_imm;
    logic [1:0]  r_mode;
    logic [4:0]  r_alu_op;
    logic [4:0]  r_rd_addr;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_flush_pending;
    logic [15:0] r_bubble_cnt;

    logic        w_load_use;
    logic        w_flush;
    logic        w_byp_1;
    logic        w_byp_2;
    logic [15:0] w_cnt_inc;

    // A load in EX whose destination is read by the instruction in ID must wait a cycle.
    assign w_load_use = r_ex_valid && r_mem_read && (r_rd_addr != 5'd0) && bus.id_valid &&
                        ((r_rd_addr == bus.rs1_addr_id) || (r_rd_addr == bus.rs2_addr_id));
    assign w_flush    = bus.flush_in || r_flush_pending;

    assign w_byp_1 = bus.wb_reg_write && (bus.wb_rd_addr != 5'd0) &&
                     (bus.wb_rd_addr == bus.rs1_addr_id);
    assign w_byp_2 = bus.wb_reg_write && (bus.wb_rd_addr != 5'd0) &&
                     (bus.wb_rd_addr == bus.rs2_addr_id);

    assign w_cnt_inc = (r_bubble_cnt == 16'hFFFF) ? r_bubble_cnt : r_bubble_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid      <= 1'b0;
            r_pc_ex         <= 32'd0;
            r_reg_1         <= 32'd0;
            r_reg_2         <= 32'd0;
            r_imm           <= 32'd0;
            r_mode          <= NOP_MODE;
            r_alu_op        <= NOP_ALU_OP;
            r_rd_addr       <= 5'd0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_flush_pending <= 1'b0;
            r_bubble_cnt    <= 16'd0;
        end else if (bus.mem_stall_in) begin
            // Everything holds; only remember a flush so it is not lost.
            if (bus.flush_in) begin
                r_flush_pending <= 1'b1;
            end
        end else if (w_flush || w_load_use) begin
            // Flush and bubble share one slot kill; data registers keep their contents.
            r_ex_valid      <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_alu_op        <= NOP_ALU_OP;
            r_mode          <= NOP_MODE;
            r_rd_addr       <= 5'd0;
            r_flush_pending <= 1'b0;
            r_bubble_cnt    <= w_cnt_inc;
        end else begin
            r_ex_valid  <= bus.id_valid;
            r_pc_ex     <= bus.pc_id;
            r_reg_1     <= w_byp_1 ? bus.wb_data : bus.reg_1_id;
            r_reg_2     <= w_byp_2 ? bus.wb_data : bus.reg_2_id;
            r_imm       <= bus.imm_data_id;
            r_mode      <= bus.alu_mode_select_id;
            r_alu_op    <= bus.alu_op_id;
            r_rd_addr   <= bus.rd_addr_id;
            r_reg_write <= bus.id_valid && bus.reg_write_id;
            r_mem_read  <= bus.id_valid && bus.mem_read_id;
            r_mem_write <= bus.id_valid && bus.mem_write_id;
        end
    end

    assign bus.id_stall_out       = w_load_use || bus.mem_stall_in;
    assign bus.ex_valid           = r_ex_valid;
    assign bus.pc_ex              = r_pc_ex;
    assign bus.reg_1_out          = r_reg_1;
    assign bus.reg_2_out          = r_reg_2;
    assign bus.imm_data_out       = r_imm;
    assign bus.alu_mode_select_ex = r_mode;
    assign bus.alu_op_ex          = r_alu_op;
    assign bus.rd_addr_ex         = r_rd_addr;
    assign bus.reg_write_ex       = r_reg_write;
    assign bus.mem_read_ex        = r_mem_read;
    assign bus.mem_write_ex       = r_mem_write;
    assign bus.bubble_cnt_out     = r_bubble_cnt;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter NOP_ALU_OP, default 5'd0, alu_op value driven when a bubble is inserted.
REQ-002 Parameter NOP_MODE, default 2'd0, alu_mode_select value driven when a bubble is inserted.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  decode holds a valid instruction.
REQ-006 pc_id, reg_1_id, reg_2_id, imm_data_id  in  32 each  decode PC, rs1 data, rs2 data, immediate.
REQ-007 rs1_addr_id, rs2_addr_id, rd_addr_id  in  5 each  decode register addresses.
REQ-008 alu_mode_select_id  in  2; alu_op_id  in  5  decode ALU controls.
REQ-009 reg_write_id, mem_read_id, mem_write_id  in  1 each  decode control bits.
REQ-010 wb_reg_write  in  1; wb_rd_addr  in  5; wb_data  in  32  same-cycle writeback port.
REQ-011 flush_in  in  1  taken branch/jump from EX; kill the instruction in ID.
REQ-012 mem_stall_in  in  1  downstream stall; hold all EX-side registers.
REQ-013 ex_valid  out  1; pc_ex, reg_1_out, reg_2_out, imm_data_out  out  32 each  registered EX operands, feeding the ALU stage directly.
REQ-014 alu_mode_select_ex  out  2; alu_op_ex  out  5; rd_addr_ex  out  5; reg_write_ex, mem_read_ex, mem_write_ex  out  1 each.
REQ-015 id_stall_out  out  1  combinational; freeze PC and IF/ID register.
REQ-016 bubble_cnt_out  out  16  saturating count of inserted bubbles.

Function
REQ-017 Load-use hazard (combinational) = ex_valid & mem_read_ex & rd_addr_ex!=0 & id_valid & (rd_addr_ex==rs1_addr_id | rd_addr_ex==rs2_addr_id).
REQ-018 id_stall_out SHALL be 1 when load-use hazard is 1 or mem_stall_in is 1; otherwise 0.
REQ-019 Per-edge priority: rst > mem_stall_in (hold) > flush (flush_in or flush_pending) > load-use (bubble) > capture.
REQ-020 Hold: every output register and bubble_cnt_out retain value.
REQ-021 Flush and bubble: ex_valid<=0, reg_write_ex/mem_read_ex/mem_write_ex<=0, alu_op_ex<=NOP_ALU_OP, alu_mode_select_ex<=NOP_MODE, rd_addr_ex<=0; data registers unchanged.
REQ-022 Capture: ex_valid<=id_valid; all *_ex/*_out registers load their *_id counterparts; control bits gated by id_valid (0 when id_valid=0).
REQ-023 Writeback bypass at capture: if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==rs1_addr_id, reg_1_out<=wb_data instead of reg_1_id; same rule independently for rs2/reg_2_out.
REQ-024 flush_pending register: set when flush_in=1 and mem_stall_in=1; cleared on first edge where mem_stall_in=0 (flush applied that edge).
REQ-025 flush_in with mem_stall_in=0 SHALL apply on that edge without touching flush_pending (stays 0).
REQ-026 Flush overrides load-use: no bubble count for a flushed slot counted twice; flush cycles count as one bubble.
REQ-027 bubble_cnt_out increments by 1 on each flush or load-use bubble edge; saturates at 16'hFFFF, no wrap.
REQ-028 Latency: one cycle ID->EX; operands valid at EX outputs the cycle after capture.
REQ-029 rd_addr 0 never triggers hazard or bypass.

Reset
REQ-030 On rst=1 at a clock edge: ex_valid=0, all control outputs 0, alu_op_ex=NOP_ALU_OP, alu_mode_select_ex=NOP_MODE, all 32-bit and 5-bit outputs 0, flush_pending=0, bubble_cnt_out=0.
REQ-031 rst SHALL override mem_stall_in, flush_in and a pending flush in the same cycle.

Verification
REQ-032 Capture: id_valid=1, pc_id=0x100, alu_op_id=5'd3, reg_1_id=0x11 -> next cycle ex_valid=1, pc_ex=0x100, alu_op_ex=3, reg_1_out=0x11.
REQ-033 Load-use: EX holds lw x5 (mem_read_ex=1, rd=5), ID has rs1=5 -> id_stall_out=1, next cycle ex_valid=0, alu_op_ex=NOP_ALU_OP, bubble_cnt_out=1; following cycle ID instruction captured.
REQ-034 Bypass: wb_reg_write=1, wb_rd_addr=7, wb_data=0xDEAD, rs2_addr_id=7, reg_2_id=0x1 -> reg_2_out=0xDEAD; repeat with wb_rd_addr=0 -> reg_2_out=0x1.
REQ-035 Flush under stall: flush_in=1 with mem_stall_in=1 for 2 cycles -> outputs held, flush_pending=1; stall drops -> next edge ex_valid=0, flush_pending=0, bubble_cnt_out+1.
REQ-036 Saturation: preload 0xFFFE bubbles, force 3 more -> bubble_cnt_out=0xFFFF.
REQ-037 Reset mid-operation: rst=1 during stall with flush_pending=1 -> all outputs at REQ-030 values next cycle, flush not applied later.
